ascii_frame_sequencer: RTL and testbench

- Shares one signed-integer-to-ASCII conversion path between `N_REQ` value producers, such as sensor or telemetry channels.
- Grants requesters round-robin, latches the value, clamps it to ±999, and extracts decimal digits by iterative subtraction (no dividers).
- Streams the result as a byte frame to the UART transmitter over a valid/ready handshake.
- Sits between the value producers and the UART TX byte interface.

---
 rtl/ascii_frame_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ascii_frame_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_frame_sequencer.sv
// ============================================================================
//  Module      : ascii_frame_sequencer
//  Description : Round-robin arbiter feeding a shared signed-int to ASCII
//                converter ("+ddd"/"-ddd" plus terminator) streamed over a
//                valid/ready byte interface. ASCII_FRAME_CRLF_EN selects a
//                CR LF terminator instead of LF only.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascii_frame_sequencer #(
    parameter int N_REQ = 2,
    parameter int SEL_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [32*N_REQ-1:0]    req_value,
    output logic [N_REQ-1:0]       req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic [SEL_W-1:0]       cur_src
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_hund = 2'd1;
    localparam logic [1:0] c_st_tens = 2'd2;
    localparam logic [1:0] c_st_send = 2'd3;

`ifdef ASCII_FRAME_CRLF_EN
    localparam logic [2:0] c_last_idx = 3'd5;
`else
    localparam logic [2:0] c_last_idx = 3'd4;
`endif

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] r_cur_src;
    logic             r_neg;
    logic [9:0]       r_rem;
    logic [3:0]       r_h;
    logic [3:0]       r_t;
    logic [2:0]       r_idx;
    logic [7:0]       r_tx_data;
    logic             r_tx_valid;

    logic             w_any;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_grant;
    logic [31:0]      w_sel_value;
    logic [32:0]      w_mag;
    logic [9:0]       w_mag_sat;
    logic             w_hs;
    logic [2:0]       w_nidx;
    logic [7:0]       w_next_byte;

    // Cyclic search starting at r_rr_ptr; iterating backwards lets the
    // closest candidate overwrite farther ones.
    always_comb begin : p_arb
        logic [2**SEL_W-1:0] v_valid;
        logic [SEL_W:0]      v_sum;
        v_valid              = '0;
        v_valid[N_REQ-1:0]   = req_valid;
        v_sum                = '0;
        w_any                = 1'b0;
        w_gnt_idx            = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_sum = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
            if (v_sum >= (SEL_W+1)'(N_REQ)) begin
                v_sum = v_sum - (SEL_W+1)'(N_REQ);
            end
            if (v_valid[v_sum[SEL_W-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = v_sum[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_value = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_sel_value = req_value[32*i +: 32];
            end
        end
    end

    // 33-bit magnitude so that -2^31 negates without wrapping.
    assign w_mag     = w_sel_value[31] ? (33'd0 - {1'b1, w_sel_value}) : {1'b0, w_sel_value};
    assign w_mag_sat = (w_mag > 33'd999) ? 10'd999 : w_mag[9:0];

    assign w_grant = (r_state == c_st_idle) && w_any;
    assign w_hs    = r_tx_valid && tx_ready;
    assign w_nidx  = r_idx + 3'd1;

    always_comb begin
        case (w_nidx)
            3'd1:    w_next_byte = 8'h30 + {4'h0, r_h};
            3'd2:    w_next_byte = 8'h30 + {4'h0, r_t};
            3'd3:    w_next_byte = 8'h30 + {4'h0, r_rem[3:0]};
`ifdef ASCII_FRAME_CRLF_EN
            3'd4:    w_next_byte = 8'h0D;
`endif
            default: w_next_byte = 8'h0A;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (w_any)                          w_next_state = c_st_hund;
            c_st_hund: if (r_rem < 10'd100)                w_next_state = c_st_tens;
            c_st_tens: if (r_rem < 10'd10)                 w_next_state = c_st_send;
            c_st_send: if (w_hs && (r_idx == c_last_idx))  w_next_state = c_st_idle;
            default:                                       w_next_state = c_st_idle;
        endcase
    end

    // Output logic; rst_n gating keeps req_ready low while reset is held.
    always_comb begin
        busy = (r_state != c_st_idle);
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = rst_n && w_grant && (w_gnt_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_cur_src  <= '0;
            r_neg      <= 1'b0;
            r_rem      <= '0;
            r_h        <= '0;
            r_t        <= '0;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_neg     <= w_sel_value[31];
                        r_rem     <= w_mag_sat;
                        r_h       <= '0;
                        r_t       <= '0;
                        r_cur_src <= w_gnt_idx;
                        r_rr_ptr  <= (w_gnt_idx == SEL_W'(N_REQ - 1)) ? '0 : w_gnt_idx + SEL_W'(1);
                    end
                end
                c_st_hund: begin
                    if (r_rem >= 10'd100) begin
                        r_rem <= r_rem - 10'd100;
                        r_h   <= r_h + 4'd1;
                    end
                end
                c_st_tens: begin
                    if (r_rem >= 10'd10) begin
                        r_rem <= r_rem - 10'd10;
                        r_t   <= r_t + 4'd1;
                    end else begin
                        r_idx      <= '0;
                        r_tx_data  <= r_neg ? 8'h2D : 8'h2B;
                        r_tx_valid <= 1'b1;
                    end
                end
                c_st_send: begin
                    if (w_hs) begin
                        if (r_idx == c_last_idx) begin
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_idx     <= w_nidx;
                            r_tx_data <= w_next_byte;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign cur_src  = r_cur_src;

endmodule

`default_nettype wire

// File: tb/tb_ascii_frame_sequencer.sv
// ============================================================================
//  Module      : tb_ascii_frame_sequencer
//  Description : Scoreboard bench for ascii_frame_sequencer (build with or
//                without ASCII_FRAME_CRLF_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascii_frame_sequencer;

`ifdef ASCII_FRAME_CRLF_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [63:0] req_value;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [1:0]  cur_src;

    ascii_frame_sequencer #(.N_REQ(2), .SEL_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_value (req_value),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .cur_src   (cur_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic [1:0] src;
    } exp_t;

    exp_t       sb[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         hs_cnt = 0;
    bit         mon_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic longint clamp_mag(input int value);
        longint m;
        m = (value < 0) ? -longint'(value) : longint'(value);
        if (m > 999) m = 999;
        return m;
    endfunction

    function automatic void push_frame(input int value, input logic [1:0] src);
        longint m;
        exp_t   e;
        m     = clamp_mag(value);
        e.src = src;
        e.b = (value < 0) ? 8'h2D : 8'h2B;     sb.push_back(e);
        e.b = 8'(48 + m / 100);                sb.push_back(e);
        e.b = 8'(48 + (m / 10) % 10);          sb.push_back(e);
        e.b = 8'(48 + m % 10);                 sb.push_back(e);
`ifdef ASCII_FRAME_CRLF_EN
        e.b = 8'h0D;                           sb.push_back(e);
`endif
        e.b = 8'h0A;                           sb.push_back(e);
    endfunction

    // Handshakes are evaluated at the negedge preceding the edge that takes them.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (prev_stall) begin
                chk("stall_valid", 32'(tx_valid), 32'd1);
                chk("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("byte", 32'(tx_data), 32'(e.b));
                    chk("src", 32'(cur_src), 32'(e.src));
                end
            end
            if (busy) chk("ready_when_busy", 32'(req_ready), 32'd0);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic drain(input bit rnd, input int budget);
        int cyc = 0;
        while ((sb.size() != 0 || tx_valid) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
        end
        tx_ready = 1'b1;
        if (cyc >= budget) chk("drain_timeout", 32'(sb.size()) + 32'(tx_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_value(input int src, input int value, input bit rnd);
        int     cyc;
        int     lat;
        int     hs0;
        longint m;
        m   = clamp_mag(value);
        lat = 1 + int'(m / 100) + 1 + int'((m / 10) % 10) + 1;
        hs0 = hs_cnt;
        tx_ready = 1'b1;
        req_value[32*src +: 32] = value;
        req_valid[src] = 1'b1;
        push_frame(value, 2'(src));
        #1;
        cyc = 0;
        while (!req_ready[src] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("grant_onehot", 32'(req_ready), 32'd1 << src);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) req_valid[src] = 1'b0;
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
        end while (!tx_valid && cyc < 100);
        chk("first_valid_cycle", 32'(cyc), 32'(lat));
        drain(rnd, 600);
        chk("handshakes", 32'(hs_cnt - hs0), 32'(FRAME_LEN));
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        req_valid = '0;
        req_value = '0;
        tx_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur_src", 32'(cur_src), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        run_value(0, 42, 1'b0);
        run_value(1, -100, 1'b0);
        run_value(0, 0, 1'b0);
        run_value(1, 1234, 1'b0);
        run_value(0, int'(32'h8000_0000), 1'b0);
        run_value(1, 987, 1'b1);

        // Two requesters continuously valid: strict alternation from req0.
        do_reset();
        req_value = {32'hFFFF_FFC1, 32'd7};
        push_frame(7, 2'd0);
        push_frame(-63, 2'd1);
        push_frame(7, 2'd0);
        push_frame(-63, 2'd1);
        tx_ready  = 1'b1;
        req_valid = 2'b11;
        cyc = 0;
        while (sb.size() != 0 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (sb.size() < FRAME_LEN) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        drain(1'b0, 100);

        // Asynchronous reset while byte 2 is presented.
        req_value = {32'hFFFF_FFF8, 32'd555};
        req_valid = 2'b01;
        push_frame(555, 2'd0);
        cyc = 0;
        while (sb.size() != FRAME_LEN - 2 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reached_byte2", 32'(sb.size()), 32'(FRAME_LEN - 2));
        req_valid = 2'b11;
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(tx_valid), 32'd0);
        chk("arst_tx_data", 32'(tx_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cur_src", 32'(cur_src), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk); #1;
        push_frame(555, 2'd0);
        push_frame(-8, 2'd1);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cyc = 0;
        while (sb.size() > FRAME_LEN && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        cyc = 0;
        while (sb.size() == FRAME_LEN && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 2'b00;
        drain(1'b0, 200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
